// File: rtl/demux_1ton_reg.sv
// 1-to-N demultiplexer with a combinational lane path and a registered,
// clock-enabled lane path carrying a one-hot valid flag.

module demux_1ton_reg_lane #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2,
  parameter int LANE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] comb,
  output logic [WIDTH-1:0] q,
  output logic             vld
);
  logic hit;

  assign hit  = (sel == SEL_W'(LANE));
  assign comb = hit ? in : '0;

  // Valid follows the select, not the data, so a routed zero is still marked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= '0;
      vld <= 1'b0;
    end else if (en) begin
      q   <= comb;
      vld <= hit;
    end
  end
endmodule

module demux_1ton_reg #(
  parameter int WIDTH = 1,
  parameter int SEL_W = 2,
  localparam int N    = 1 << SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   in,
  input  logic [SEL_W-1:0]   sel,
  output logic [N*WIDTH-1:0] out_comb,
  output logic [N*WIDTH-1:0] out,
  output logic [N-1:0]       out_valid
);
  for (genvar k = 0; k < N; k++) begin : g_lane
    demux_1ton_reg_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W),
      .LANE  (k)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .in    (in),
      .sel   (sel),
      .comb  (out_comb[k*WIDTH +: WIDTH]),
      .q     (out[k*WIDTH +: WIDTH]),
      .vld   (out_valid[k])
    );
  end
endmodule

// File: tb/tb_demux_1ton_reg.sv
// Scoreboarded bench for demux_1ton_reg: three configurations share clock,
// reset and enable; directed vectors carry hand-computed expectations.

module tb_demux_1ton_reg;
  logic clk, rst_n, en;

  logic       a_in;  logic       a_sel;
  logic       b_in;  logic [1:0] b_sel;
  logic [7:0] c_in;  logic [1:0] c_sel;

  logic [1:0]  a_comb, a_out, a_vld;
  logic [3:0]  b_comb, b_out, b_vld;
  logic [31:0] c_comb, c_out;
  logic [3:0]  c_vld;

  demux_1ton_reg #(.WIDTH(1), .SEL_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in(a_in), .sel(a_sel),
    .out_comb(a_comb), .out(a_out), .out_valid(a_vld));

  demux_1ton_reg #(.WIDTH(1), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in(b_in), .sel(b_sel),
    .out_comb(b_comb), .out(b_out), .out_valid(b_vld));

  demux_1ton_reg #(.WIDTH(8), .SEL_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in(c_in), .sel(c_sel),
    .out_comb(c_comb), .out(c_out), .out_valid(c_vld));

  typedef struct {
    logic [1:0]  ac, ao, av;
    logic [3:0]  bc, bo, bv;
    logic [31:0] cc, co;
    logic [3:0]  cv;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_vec  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Monitor: inputs are driven on the falling edge, so just after the rising
  // edge both the registered result and the still-stable comb path are visible.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("a_comb", e.idx, 32'(a_comb), 32'(e.ac));
      chk("a_out",  e.idx, 32'(a_out),  32'(e.ao));
      chk("a_vld",  e.idx, 32'(a_vld),  32'(e.av));
      chk("b_comb", e.idx, 32'(b_comb), 32'(e.bc));
      chk("b_out",  e.idx, 32'(b_out),  32'(e.bo));
      chk("b_vld",  e.idx, 32'(b_vld),  32'(e.bv));
      chk("c_comb", e.idx, c_comb,      e.cc);
      chk("c_out",  e.idx, c_out,       e.co);
      chk("c_vld",  e.idx, 32'(c_vld),  32'(e.cv));
    end
  end

  task automatic step(input logic r, input logic e_n,
                      input logic ai, input logic as,
                      input logic bi, input logic [1:0] bs,
                      input logic [7:0] ci, input logic [1:0] cs,
                      input logic [1:0] ac, input logic [1:0] ao, input logic [1:0] av,
                      input logic [3:0] bc, input logic [3:0] bo, input logic [3:0] bv,
                      input logic [31:0] cc, input logic [31:0] co, input logic [3:0] cv);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e_n;
    a_in = ai; a_sel = as;
    b_in = bi; b_sel = bs;
    c_in = ci; c_sel = cs;
    x.ac = ac; x.ao = ao; x.av = av;
    x.bc = bc; x.bo = bo; x.bv = bv;
    x.cc = cc; x.co = co; x.cv = cv;
    x.idx = n_vec++;
    sb.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1;
    a_in = 1'b0; a_sel = 1'b0;
    b_in = 1'b0; b_sel = 2'd0;
    c_in = 8'h00; c_sel = 2'd0;
    repeat (2) @(posedge clk);

    //   rst en  a_in/sel  b_in/sel  c_in/sel    a comb/out/vld  b comb/out/vld     c comb / out / vld
    // reset state; comb path live during reset
    step(0, 1, 1, 0, 1, 2'd0, 8'hA5, 2'd0, 2'b01, 2'b00, 2'b00, 4'b0001, 4'b0000, 4'b0000,
         32'h0000_00A5, 32'h0000_0000, 4'b0000);
    // first enabled load after release
    step(1, 1, 1, 1, 1, 2'd2, 8'hA5, 2'd2, 2'b10, 2'b10, 2'b10, 4'b0100, 4'b0100, 4'b0100,
         32'h00A5_0000, 32'h00A5_0000, 4'b0100);
    // zero data still flags the selected lane
    step(1, 1, 0, 0, 0, 2'd3, 8'h3C, 2'd1, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 4'b1000,
         32'h0000_3C00, 32'h0000_3C00, 4'b0010);
    step(1, 1, 0, 1, 1, 2'd1, 8'hFF, 2'd3, 2'b00, 2'b00, 2'b10, 4'b0010, 4'b0010, 4'b0010,
         32'hFF00_0000, 32'hFF00_0000, 4'b1000);
    // hold with en low while comb tracks new inputs
    step(1, 0, 1, 0, 0, 2'd3, 8'h11, 2'd0, 2'b01, 2'b00, 2'b10, 4'b0000, 4'b0010, 4'b0010,
         32'h0000_0011, 32'hFF00_0000, 4'b1000);
    step(1, 0, 1, 1, 1, 2'd3, 8'h22, 2'd2, 2'b10, 2'b00, 2'b10, 4'b1000, 4'b0010, 4'b0010,
         32'h0022_0000, 32'hFF00_0000, 4'b1000);
    step(1, 1, 1, 1, 1, 2'd3, 8'h80, 2'd3, 2'b10, 2'b10, 2'b10, 4'b1000, 4'b1000, 4'b1000,
         32'h8000_0000, 32'h8000_0000, 4'b1000);
    // mid-stream reset for two cycles
    step(0, 1, 1, 0, 1, 2'd1, 8'h5A, 2'd1, 2'b01, 2'b00, 2'b00, 4'b0010, 4'b0000, 4'b0000,
         32'h0000_5A00, 32'h0000_0000, 4'b0000);
    step(0, 1, 0, 1, 1, 2'd2, 8'h00, 2'd0, 2'b00, 2'b00, 2'b00, 4'b0100, 4'b0000, 4'b0000,
         32'h0000_0000, 32'h0000_0000, 4'b0000);
    // release loads in=1, sel=0
    step(1, 1, 1, 0, 1, 2'd0, 8'h01, 2'd0, 2'b01, 2'b01, 2'b01, 4'b0001, 4'b0001, 4'b0001,
         32'h0000_0001, 32'h0000_0001, 4'b0001);
    step(1, 1, 0, 1, 0, 2'd0, 8'h00, 2'd2, 2'b00, 2'b00, 2'b10, 4'b0000, 4'b0000, 4'b0001,
         32'h0000_0000, 32'h0000_0000, 4'b0100);
    // reset wins over en low
    step(0, 0, 1, 1, 1, 2'd3, 8'hA5, 2'd3, 2'b10, 2'b00, 2'b00, 4'b1000, 4'b0000, 4'b0000,
         32'hA500_0000, 32'h0000_0000, 4'b0000);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
